rd_prefetch: RTL and testbench
==============================

RD_PREFETCH -- requirements
Module: rd_prefetch

Interface
REQ-001 SHALL have parameter DATASIZE, default 8, width of FIFO data word.
REQ-002 SHALL have parameter BUFDEPTH, default 2, fixed at 2; any other value is a compile-time error.
REQ-003 SHALL have port rclk, input, 1, read-domain clock; all state SHALL be on rising edge.
REQ-004 SHALL have port rrst_n, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port rempty, input, 1, FIFO empty flag from the read-pointer/empty stage.
REQ-006 SHALL have port rinc, output, 1, read-increment request to the read-pointer/empty stage.
REQ-007 SHALL have port rdata, input, DATASIZE, FIFO memory read data at current raddr.
REQ-008 SHALL have port m_valid, output, 1, output word valid.
REQ-009 SHALL have port m_ready, input, 1, downstream accepts word.
REQ-010 SHALL have port m_data, output, DATASIZE, output word.
REQ-011 SHALL have port level, output, 2, number of words held in the prefetch buffer (0..2).

Function
REQ-012 Block SHALL convert the rempty/rinc FIFO read port into a valid/ready stream through a 2-entry buffer (entries buf0/buf1, 1-bit wr_ptr/rd_ptr, 2-bit count).
REQ-013 pop SHALL equal m_valid & m_ready; m_valid SHALL equal (count != 0); m_data SHALL equal buf[rd_ptr].
REQ-014 credits SHALL equal count + inflight - pop; rinc SHALL equal ~rempty & (credits < 2), combinational.
REQ-015 rinc SHALL never be 1 while rempty is 1 (no underflow of the FIFO).
REQ-016 push SHALL occur in the cycle rdata is valid for a granted rinc (timing per REQ-024/025); push writes rdata into buf[wr_ptr] and toggles wr_ptr.
REQ-017 count SHALL update as count + push - pop each cycle; simultaneous push and pop SHALL leave count unchanged and both pointers advance.
REQ-018 Push when count==2 and pop==0 SHALL be impossible by construction; a bench assertion SHALL flag it.
REQ-019 Once m_valid is 1, m_valid and m_data SHALL remain stable until pop.
REQ-020 Sustained throughput SHALL be 1 word/cycle when rempty=0 and m_ready=1.
REQ-021 level SHALL equal count, registered, no extra latency.

Reset
REQ-022 On rrst_n=0 (asynchronous): count=0, wr_ptr=0, rd_ptr=0, inflight=0, buf0=buf1=0, so m_valid=0, m_data=0, level=0.
REQ-023 Reset mid-operation SHALL discard buffered and in-flight words; first valid after release SHALL be the first word written after the FIFO's own reset.

Configuration
REQ-024 With macro RD_PREFETCH_REGRD_EN undefined: memory read is combinational; push = rinc in same cycle (rdata sampled with rinc); inflight constant 0; m_valid rises 1 cycle after rempty falls.
REQ-025 With RD_PREFETCH_REGRD_EN defined: memory read is registered (1-cycle latency); inflight register = rinc delayed 1 cycle, reset 0; push = inflight; m_valid rises 2 cycles after rempty falls.

Structure
REQ-026 Default DATASIZE and ADDRSIZE constants SHALL live in the shared package fifo_pkg, alongside the FIFO's other width constants.
REQ-027 Buffer storage and pointers SHALL be one sub-module rd_skid_buf (push, pop, din, dout, count); credit/rinc logic stays in rd_prefetch.

Verification
REQ-028 Reset, rempty=1, m_ready=1, 10 cycles -> rinc=0, m_valid=0, level=0 throughout.
REQ-029 rempty falls at cycle T with rdata=0xA5, m_ready=0 -> m_valid=1, m_data=0xA5 at T+1 (T+2 with RD_PREFETCH_REGRD_EN), stable until m_ready.
REQ-030 rempty=0 for 16 words 0x00..0x0F, m_ready=1 -> 16 consecutive output beats in order, no gaps after first, level<=2.
REQ-031 Stream running, m_ready=0 for 5 cycles -> level reaches 2, rinc=0 while credits=2, no loss/duplication on resume.
REQ-032 m_ready toggles every cycle with rempty toggling pseudo-randomly, 1000 words -> scoreboard matches in order, rinc never 1 with rempty=1.
REQ-033 rrst_n pulsed low with level=2 -> m_valid=0, level=0 asynchronously; after release only post-reset words appear.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg -- shared width constants for the async FIFO and its read-side
// helpers (pointer/empty stage, prefetch buffer).
//   DATASIZE : default FIFO data word width
//   ADDRSIZE : default FIFO memory address width
//   PF_DEPTH : prefetch buffer depth (the buffer is built for exactly 2)
package fifo_pkg;
  localparam int DATASIZE = 8;
  localparam int ADDRSIZE = 4;
  localparam int PF_DEPTH = 2;

  typedef logic [1:0] pf_cnt_t;
endpackage

// File: rtl/rd_skid_buf.sv
// rd_skid_buf -- two-entry ring buffer behind the FIFO read port.
// Ports:
//   rclk, rrst_n : read-domain clock, async active-low reset
//   push, din    : write din into the entry at wr_ptr
//   pop          : retire the entry at rd_ptr
//   dout         : entry at rd_ptr (head of buffer)
//   count        : number of entries held (0..2)
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATASIZE = fifo_pkg::DATASIZE
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                push,
  input  logic                pop,
  input  logic [DATASIZE-1:0] din,
  output logic [DATASIZE-1:0] dout,
  output logic [1:0]          count
);

  logic [DATASIZE-1:0] buf0, buf1;
  logic                wr_ptr, rd_ptr;
  pf_cnt_t             cnt;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      buf0   <= '0;
      buf1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      if (push) begin
        if (wr_ptr) buf1 <= din;
        else        buf0 <= din;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout  = rd_ptr ? buf1 : buf0;
  assign count = cnt;

endmodule

// File: rtl/rd_prefetch.sv
// rd_prefetch -- turns the FIFO rempty/rinc read port into a valid/ready
// stream through a 2-entry prefetch buffer.
// Optional feature: define RD_PREFETCH_REGRD_EN when the FIFO memory read is
// registered (rdata valid one cycle after rinc). Default: combinational read.
// Ports:
//   rclk, rrst_n     : read-domain clock, async active-low reset
//   rempty           : FIFO empty flag
//   rinc             : read-increment request to the FIFO
//   rdata            : FIFO memory read data
//   m_valid, m_ready : output handshake
//   m_data           : output word
//   level            : words held in the prefetch buffer (0..2)
module rd_prefetch
  import fifo_pkg::*;
#(
  parameter int DATASIZE = fifo_pkg::DATASIZE,
  parameter int BUFDEPTH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rempty,
  output logic                rinc,
  input  logic [DATASIZE-1:0] rdata,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATASIZE-1:0] m_data,
  output logic [1:0]          level
);

  generate
    if (BUFDEPTH != PF_DEPTH) begin : g_bad_depth
      $error("rd_prefetch: BUFDEPTH must be 2");
    end
  endgenerate

  logic       push, pop, inflight;
  logic [1:0] count;
  logic [2:0] credits;

  assign m_valid = (count != 2'd0);
  assign pop     = m_valid & m_ready;
  assign level   = count;

  // Slots already spoken for: held words plus a read still on its way,
  // less the word leaving this cycle. Never underflows since pop implies count>0.
  assign credits = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign rinc    = ~rempty & (credits < 3'd2);

`ifdef RD_PREFETCH_REGRD_EN
  // Registered memory: data for a granted read shows up next cycle.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) inflight <= 1'b0;
    else         inflight <= rinc;
  end
  assign push = inflight;
`else
  assign inflight = 1'b0;
  assign push     = rinc;
`endif

  rd_skid_buf #(.DATASIZE(DATASIZE)) u_buf (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .push   (push),
    .pop    (pop),
    .din    (rdata),
    .dout   (m_data),
    .count  (count)
  );

endmodule

// File: tb/tb_rd_prefetch.sv
// tb_rd_prefetch -- directed + random bench for rd_prefetch. The FIFO is
// modelled as a word queue; the prefetch buffer as a queue of held words.
module tb_rd_prefetch;
  localparam int DW = 8;
`ifdef RD_PREFETCH_REGRD_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b0;
  logic          rempty = 1'b1;
  logic          rinc;
  logic [DW-1:0] rdata = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [1:0]    level;

  rd_prefetch #(.DATASIZE(DW), .BUFDEPTH(2)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rempty  (rempty),
    .rinc    (rinc),
    .rdata   (rdata),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .level   (level)
  );

  always #5 rclk = ~rclk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] src_q[$];   // words sitting in the FIFO
  logic [DW-1:0] held_q[$];  // words the prefetch buffer should hold
  logic [DW-1:0] exp_q[$];   // expected output order
  logic          pend_v = 1'b0;
  logic [DW-1:0] pend_w = '0;
  int            n_acc = 0;
  logic          last_pop = 1'b0;
  logic          first_seen = 1'b0;
  logic [DW-1:0] first_word = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [DW-1:0] w);
    src_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // One clock: drive inputs at the falling edge, check, advance the model
  // by what happens at the next rising edge.
  task automatic cyc(input logic rdy, input logic av);
    logic          pop;
    logic          exp_rinc;
    int            credits;
    logic [DW-1:0] w;
    m_ready = rdy;
    rempty  = !(av && src_q.size() > 0);
`ifdef RD_PREFETCH_REGRD_EN
    rdata = pend_w;
`else
    rdata = (src_q.size() > 0) ? src_q[0] : '0;
`endif
    #1;
    chk("level", level, held_q.size());
    chk("m_valid", m_valid, held_q.size() != 0);
    if (held_q.size() > 0) chk("m_data", m_data, held_q[0]);
    pop      = m_valid & m_ready;
    credits  = held_q.size() + int'(pend_v) - int'(pop);
    exp_rinc = !rempty && credits < 2;
    chk("rinc", rinc, exp_rinc);
    chk("rinc_while_empty", rinc & rempty, 0);
    last_pop = pop;
    if (pop) begin
      n_acc++;
      if (!first_seen) begin
        first_seen = 1'b1;
        first_word = m_data;
      end
      if (exp_q.size() == 0) chk("sb_extra_beat", 1, 0);
      else                   chk("sb_order", m_data, exp_q.pop_front());
      if (held_q.size() > 0) void'(held_q.pop_front());
    end
`ifdef RD_PREFETCH_REGRD_EN
    if (pend_v) held_q.push_back(pend_w);
    pend_v = rinc;
    if (rinc && src_q.size() > 0) pend_w = src_q.pop_front();
`else
    if (rinc && src_q.size() > 0) begin
      w = src_q.pop_front();
      held_q.push_back(w);
    end
`endif
    chk("push_when_full", held_q.size() > 2, 0);
    @(negedge rclk);
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while ((src_q.size() > 0 || held_q.size() > 0 || pend_v) && k < bound) begin
      cyc(1'b1, 1'b1);
      k++;
    end
    chk("drain_done", src_q.size() + held_q.size() + int'(pend_v), 0);
  endtask

  initial begin
    int start_acc, gaps, first_i, k;
    // Reset state
    repeat (2) @(negedge rclk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_m_data", m_data, 0);
    rrst_n = 1'b1;

    // Empty FIFO, ready high: nothing happens
    repeat (10) cyc(1'b1, 1'b1);

    // First-word latency and stability with m_ready low
    load(8'hA5);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1);
      chk("lat_m_valid", m_valid, (i + 1) >= LAT);
      if (m_valid) chk("lat_m_data", m_data, 8'hA5);
    end
    drain(10);

    // 16-word streaming throughput
    for (int i = 0; i < 16; i++) load(DW'(i));
    start_acc = n_acc; gaps = 0; first_i = -1;
    for (int i = 0; i < 40 && (n_acc - start_acc) < 16; i++) begin
      cyc(1'b1, 1'b1);
      if (last_pop && first_i < 0) first_i = i;
      else if (!last_pop && first_i >= 0) gaps++;
    end
    chk("stream_beats", n_acc - start_acc, 16);
    chk("stream_gaps", gaps, 0);
    drain(10);

    // Backpressure: stall 5 cycles mid-stream
    for (int i = 0; i < 32; i++) load(8'h20 + DW'(i));
    start_acc = n_acc;
    repeat (6) cyc(1'b1, 1'b1);
    repeat (5) cyc(1'b0, 1'b1);
    chk("stall_level", level, 2);
    drain(100);
    chk("stall_beats", n_acc - start_acc, 32);
    chk("stall_exp_empty", exp_q.size(), 0);

    // Asynchronous reset with a full buffer
    for (int i = 0; i < 16; i++) load(8'h40 + DW'(i));
    repeat (4) cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b1);
    chk("pre_rst_level", level, 2);
    rempty = 1'b1;
    rrst_n = 1'b0;
    #1;
    chk("async_rst_m_valid", m_valid, 0);
    chk("async_rst_level", level, 0);
    src_q.delete(); held_q.delete(); exp_q.delete();
    pend_v = 1'b0; pend_w = '0;
    @(negedge rclk); @(negedge rclk);
    for (int i = 0; i < 8; i++) load(8'h80 + DW'(i));
    first_seen = 1'b0;
    start_acc = n_acc;
    rrst_n = 1'b1;
    drain(50);
    chk("post_rst_first", first_word, 8'h80);
    chk("post_rst_beats", n_acc - start_acc, 8);

    // Random: m_ready toggling, rempty gated randomly, 1000 words
    for (int i = 0; i < 1000; i++) load(DW'($urandom_range(0, 255)));
    start_acc = n_acc;
    k = 0;
    while ((n_acc - start_acc) < 1000 && k < 8000) begin
      cyc(k[0], 1'($urandom_range(0, 1)));
      k++;
    end
    chk("rand_beats", n_acc - start_acc, 1000);
    chk("rand_exp_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
